// File: rtl/iob_cache_be_mem_pkg.sv
// Shared types and constants for the iob_cache_be_mem back-end memory model.
package iob_cache_be_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10)
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/iob_cache_be_mem_if.sv
// IOb request/response bundle between the cache back-end master and the memory model.
interface iob_cache_be_mem_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
);
  logic                  iob_valid;
  logic [ADDR_W-1:0]     iob_addr;
  logic [DATA_W-1:0]     iob_wdata;
  logic [DATA_W/8-1:0]   iob_wstrb;
  logic                  iob_rvalid;
  logic [DATA_W-1:0]     iob_rdata;
  logic                  iob_ready;

  modport master (
    output iob_valid, iob_addr, iob_wdata, iob_wstrb,
    input  iob_rvalid, iob_rdata, iob_ready
  );

  modport slave (
    input  iob_valid, iob_addr, iob_wdata, iob_wstrb,
    output iob_rvalid, iob_rdata, iob_ready
  );
endinterface

// File: rtl/iob_ram_sp_be.sv
// Single-port RAM with per-byte write enables and a registered read port (read-before-write).
module iob_ram_sp_be #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                en_i,
  input  logic [DATA_W/8-1:0] we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   d_i,
  output logic [DATA_W-1:0]   d_o
);
  localparam int NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] dout_q;

  // NOTE: the array and its output register have no reset; a reset would
  // turn the RAM into a huge register file instead of a memory macro.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (we_i[i]) mem[addr_i][i*8 +: 8] <= d_i[i*8 +: 8];
      end
      dout_q <= mem[addr_i];
    end
  end

  assign d_o = dout_q;

endmodule

// File: rtl/iob_cache_be_mem.sv
// IOb subordinate memory model with WAIT_CYC wait states per request.
// Define IOB_CACHE_BE_MEM_STALL_EN for LFSR-driven random back-pressure in IDLE.
module iob_cache_be_mem
  import iob_cache_be_mem_pkg::*;
#(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 3
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_i,
  iob_cache_be_mem_if.slave iob_s
);
  localparam int NBYTES     = DATA_W / 8;
  localparam int NBYTES_W   = $clog2(NBYTES);
  localparam int RAM_ADDR_W = ADDR_W - NBYTES_W;
  localparam logic [7:0] CNT_INIT = (WAIT_CYC > 0) ? 8'(WAIT_CYC - 1) : 8'd0;

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [RAM_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [NBYTES-1:0]     wstrb_q, wstrb_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_W-1:0]     ram_dout;
  logic                  ram_en;
  logic                  ready;
  logic                  unused_addr_lsb;

  // Byte offset within the word never reaches the RAM.
  assign unused_addr_lsb = ^iob_s.iob_addr[NBYTES_W-1:0];

`ifdef IOB_CACHE_BE_MEM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = lfsr_next(lfsr_q);

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i)     lfsr_q <= LFSR_SEED;
    else if (cke_i) lfsr_q <= lfsr_d;
  end

  assign ready = (state_q == IDLE) && lfsr_q[0];
`else
  assign ready = (state_q == IDLE);
`endif

  // NOTE: every signal gets its default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    ram_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (iob_s.iob_valid && ready) begin
          addr_d  = iob_s.iob_addr[ADDR_W-1:NBYTES_W];
          wdata_d = iob_s.iob_wdata;
          wstrb_d = iob_s.iob_wstrb;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_CYC == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 8'd0) state_d = ACCESS;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ACCESS: begin
        ram_en  = 1'b1;
        state_d = (wstrb_q != '0) ? IDLE : RESP;
      end
      RESP: begin
        rvalid_d = 1'b1;
        rdata_d  = ram_dout;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else if (cke_i) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  iob_ram_sp_be #(
    .ADDR_W(RAM_ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk_i (clk_i),
    .en_i  (ram_en && cke_i),
    .we_i  (wstrb_q),
    .addr_i(addr_q),
    .d_i   (wdata_q),
    .d_o   (ram_dout)
  );

  assign iob_s.iob_ready  = ready;
  assign iob_s.iob_rvalid = rvalid_q;
  assign iob_s.iob_rdata  = rdata_q;

endmodule

// File: tb/tb_iob_cache_be_mem.sv
// Directed bench for iob_cache_be_mem: one instance with WAIT_CYC=3, one with WAIT_CYC=0.
module tb_iob_cache_be_mem;
  localparam int WIN = 8;

  logic clk = 1'b0;
  logic cke;
  logic arst;
  int   checks = 0;
  int   errors = 0;
  bit   seen_stall = 1'b0;

  always #5 clk = ~clk;

  iob_cache_be_mem_if #(.ADDR_W(24), .DATA_W(32)) bus3 ();
  iob_cache_be_mem_if #(.ADDR_W(12), .DATA_W(32)) bus0 ();

  iob_cache_be_mem #(.ADDR_W(24), .DATA_W(32), .WAIT_CYC(3)) u_dut3 (
    .clk_i(clk), .cke_i(cke), .arst_i(arst), .iob_s(bus3)
  );

  iob_cache_be_mem #(.ADDR_W(12), .DATA_W(32), .WAIT_CYC(0)) u_dut0 (
    .clk_i(clk), .cke_i(cke), .arst_i(arst), .iob_s(bus0)
  );

  typedef struct {
    bit          d0;
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic drive(input bit d0, input bit v, input logic [23:0] a,
                       input logic [31:0] wd, input logic [3:0] ws);
    if (d0) begin
      bus0.iob_valid = v; bus0.iob_addr = a[11:0]; bus0.iob_wdata = wd; bus0.iob_wstrb = ws;
    end else begin
      bus3.iob_valid = v; bus3.iob_addr = a; bus3.iob_wdata = wd; bus3.iob_wstrb = ws;
    end
  endtask

  function automatic bit rdy(input bit d0);
    return d0 ? bus0.iob_ready : bus3.iob_ready;
  endfunction

  function automatic logic [31:0] tbl(input int i);
    return 32'hC0DE0000 | (32'(i) * 32'h00000111);
  endfunction

  task automatic wait_ready(input bit d0);
    int n = 0;
    while (!rdy(d0) && n < 64) begin
      seen_stall = 1'b1;
      n++;
      @(negedge clk);
    end
    if (!rdy(d0)) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: ready still 0 after %0d cycles, expected 1", n);
    end
  endtask

  // Sample index j = number of edges after the accept edge.
  task automatic do_req(input bit d0, input logic [23:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, output int first_ready,
                        output int first_rvalid, output int n_rvalid, output logic [31:0] rd);
    first_ready = -1; first_rvalid = -1; n_rvalid = 0; rd = '0;
    wait_ready(d0);
    drive(d0, 1'b1, a, wd, ws);
    @(negedge clk);
    drive(d0, 1'b0, 24'h0, 32'h0, 4'h0);
    for (int j = 0; j < WIN; j++) begin
      if (rdy(d0) && first_ready < 0) first_ready = j;
      if (d0 ? bus0.iob_rvalid : bus3.iob_rvalid) begin
        n_rvalid++;
        if (first_rvalid < 0) begin
          first_rvalid = j;
          rd = d0 ? bus0.iob_rdata : bus3.iob_rdata;
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[16];
    int          fr, fv, nv, j1, j2, idx;
    logic [31:0] rd, d1, d2;

    vecs[0]  = '{1'b0, 24'h000010, 32'hDEADBEEF, 4'hF, 32'h0,          4};
    vecs[1]  = '{1'b0, 24'h000010, 32'h0,        4'h0, 32'hDEADBEEF,   5};
    vecs[2]  = '{1'b0, 24'h000010, 32'h000000AA, 4'h1, 32'h0,          4};
    vecs[3]  = '{1'b0, 24'h000010, 32'h0,        4'h0, 32'hDEADBEAA,   5};
    vecs[4]  = '{1'b0, 24'h000013, 32'h77000000, 4'h8, 32'h0,          4};
    vecs[5]  = '{1'b0, 24'h000012, 32'h0,        4'h0, 32'h77ADBEAA,   5};
    vecs[6]  = '{1'b0, 24'h000020, 32'h12345678, 4'hF, 32'h0,          4};
    vecs[7]  = '{1'b0, 24'h000030, 32'h11111111, 4'hF, 32'h0,          4};
    vecs[8]  = '{1'b0, 24'hFFFFFC, 32'h0BADF00D, 4'hF, 32'h0,          4};
    vecs[9]  = '{1'b0, 24'hFFFFFF, 32'h0,        4'h0, 32'h0BADF00D,   5};
    vecs[10] = '{1'b1, 24'h000004, 32'hA5A5A5A5, 4'hF, 32'h0,          1};
    vecs[11] = '{1'b1, 24'h000004, 32'h0,        4'h0, 32'hA5A5A5A5,   2};
    vecs[12] = '{1'b1, 24'h000004, 32'h0000BB00, 4'h2, 32'h0,          1};
    vecs[13] = '{1'b1, 24'h000005, 32'h0,        4'h0, 32'hA5A5BBA5,   2};
    vecs[14] = '{1'b0, 24'h000020, 32'h0,        4'h0, 32'h12345678,   5};
    vecs[15] = '{1'b0, 24'h000010, 32'h0,        4'h0, 32'h77ADBEAA,   5};

    cke  = 1'b1;
    arst = 1'b1;
    drive(1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 24'h0, 32'h0, 4'h0);
    @(negedge clk);
    check("rst_ready3",  32'(bus3.iob_ready),  32'd1);
    check("rst_rvalid3", 32'(bus3.iob_rvalid), 32'd0);
    check("rst_rdata3",  bus3.iob_rdata,       32'h0);
    check("rst_ready0",  32'(bus0.iob_ready),  32'd1);
    check("rst_rvalid0", 32'(bus0.iob_rvalid), 32'd0);
    arst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      do_req(vecs[i].d0, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, fr, fv, nv, rd);
      if (vecs[i].wstrb != 4'h0) begin
`ifndef IOB_CACHE_BE_MEM_STALL_EN
        check($sformatf("vec%0d_wr_ready_lat", i), 32'(fr), 32'(vecs[i].exp_lat));
`endif
        check($sformatf("vec%0d_wr_no_rvalid", i), 32'(nv), 32'd0);
      end else begin
        check($sformatf("vec%0d_rd_lat", i),    32'(fv), 32'(vecs[i].exp_lat));
        check($sformatf("vec%0d_rd_data", i),   rd,      vecs[i].exp_rdata);
        check($sformatf("vec%0d_rd_count", i),  32'(nv), 32'd1);
        check($sformatf("vec%0d_rd_hold", i),
              vecs[i].d0 ? bus0.iob_rdata : bus3.iob_rdata, vecs[i].exp_rdata);
      end
    end

`ifndef IOB_CACHE_BE_MEM_STALL_EN
    // Second request held valid while busy: accepted on the first IDLE edge.
    nv = 0; j1 = -1; j2 = -1; d1 = '0; d2 = '0;
    drive(1'b0, 1'b1, 24'h000010, 32'h0, 4'h0);
    @(negedge clk);
    drive(1'b0, 1'b1, 24'h000020, 32'h0, 4'h0);
    for (int j = 0; j < 16; j++) begin
      if (bus3.iob_rvalid) begin
        nv++;
        if (j1 < 0) begin j1 = j; d1 = bus3.iob_rdata; end
        else begin j2 = j; d2 = bus3.iob_rdata; end
      end
      if (j == 6) drive(1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
      @(negedge clk);
    end
    check("busy_rvalid_count", 32'(nv), 32'd2);
    check("busy_first_lat",    32'(j1), 32'd5);
    check("busy_first_data",   d1,      32'h77ADBEAA);
    check("busy_second_lat",   32'(j2), 32'd11);
    check("busy_second_data",  d2,      32'h12345678);
`endif

    // Clock enable low for 5 cycles during WAIT delays rvalid by 5.
    nv = 0; j1 = -1; d1 = '0;
    wait_ready(1'b0);
    drive(1'b0, 1'b1, 24'h000020, 32'h0, 4'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
    for (int j = 0; j < 16; j++) begin
      if (bus3.iob_rvalid) begin
        nv++;
        if (j1 < 0) begin j1 = j; d1 = bus3.iob_rdata; end
      end
      if (j == 1) cke = 1'b0;
      if (j == 6) cke = 1'b1;
      @(negedge clk);
    end
    check("cke_rd_lat",   32'(j1), 32'd10);
    check("cke_rd_data",  d1,      32'h12345678);
    check("cke_rd_count", 32'(nv), 32'd1);

    // Reset in WAIT drops the pending write.
    wait_ready(1'b0);
    drive(1'b0, 1'b1, 24'h000030, 32'hCAFEF00D, 4'hF);
    @(negedge clk);
    drive(1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
    @(negedge clk);
    arst = 1'b1;
    #1;
    check("midwait_rst_ready",  32'(bus3.iob_ready),  32'd1);
    check("midwait_rst_rvalid", 32'(bus3.iob_rvalid), 32'd0);
    check("midwait_rst_rdata",  bus3.iob_rdata,       32'h0);
    @(negedge clk);
    check("midwait_rst_next_ready", 32'(bus3.iob_ready), 32'd1);
    arst = 1'b0;
    @(negedge clk);
    do_req(1'b0, 24'h000030, 32'h0, 4'h0, fr, fv, nv, rd);
    check("dropped_write_data", rd,      32'h11111111);
    check("dropped_write_lat",  32'(fv), 32'd5);

    // Reset while rvalid is high clears it immediately.
    wait_ready(1'b0);
    drive(1'b0, 1'b1, 24'h000020, 32'h0, 4'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 24'h0, 32'h0, 4'h0);
    repeat (5) @(negedge clk);
    check("pre_rst_rvalid", 32'(bus3.iob_rvalid), 32'd1);
    arst = 1'b1;
    #1;
    check("rst_clears_rvalid", 32'(bus3.iob_rvalid), 32'd0);
    @(negedge clk);
    arst = 1'b0;
    @(negedge clk);

    // Random reads of a preloaded 16-word table.
    for (int i = 0; i < 16; i++) begin
      do_req(1'b0, 24'h000100 + 24'(i * 4), tbl(i), 4'hF, fr, fv, nv, rd);
    end
    for (int n = 0; n < 100; n++) begin
      idx = int'($urandom_range(15, 0));
      do_req(1'b0, 24'h000100 + 24'(idx * 4), 32'h0, 4'h0, fr, fv, nv, rd);
      check($sformatf("rand%0d_idx%0d", n, idx), rd, tbl(idx));
    end

`ifdef IOB_CACHE_BE_MEM_STALL_EN
    check("stall_seen", 32'(seen_stall), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
